// File: rtl/bht_ctrl_pkg.sv
// Shared definitions for the branch-history table controller: counter
// encodings, default geometry, FSM states and helpers shared by the fetch
// and commit paths.
package bht_ctrl_pkg;

  localparam int unsigned IdxWDefault = 7;

  // 2-bit saturating counter encodings
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } bht_state_e;

  // Word address of a PC; the table index is its low IDX_W bits, i.e.
  // pc[IDX_W+1:2]. Both fetch and commit go through this one definition.
  function automatic logic [29:0] pc_word(input logic [31:0] pc);
    return pc[31:2];
  endfunction

  // Saturation is tested before the add/subtract so the counter never wraps.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end else begin
      res = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bht_update_fifo.sv
// Small synchronous FIFO holding pending table writes {idx, next_ctr}.
// Depth must be a power of two so the pointers wrap naturally.
module bht_update_fifo #(
  parameter int unsigned DataW = 9,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             pop_i,
  output logic [DataW-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // Guard against overflow/underflow even if the caller misbehaves
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (PtrW + 1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (PtrW + 1)'(1);
    end
  end

  // Pointer and occupancy registers; reset empties the queue
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while empty so no reset
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/bht_ctrl.sv
// Branch-history table sequencer and port arbiter. Sweeps the table to
// weakly-not-taken after reset, then shares the single RAM port between
// fetch lookups and queued commit-time counter writes.
module bht_ctrl
  import bht_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W      = IdxWDefault,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rdy_i,
  input  logic             if_req_i,
  input  logic [31:0]      if_pc_i,
  output logic             if_stall_o,
  output logic             if_resp_valid_o,
  output logic             if_predict_o,
  output logic [1:0]       if_ctr_o,
  input  logic             cm_valid_i,
  input  logic [31:0]      cm_pc_i,
  input  logic             cm_taken_i,
  input  logic [1:0]       cm_ctr_i,
  output logic             cm_ready_o,
  output logic             tbl_en_o,
  output logic             tbl_we_o,
  output logic [IDX_W-1:0] tbl_addr_o,
  output logic [1:0]       tbl_wdata_o,
  input  logic [1:0]       tbl_rdata_i,
  output logic             init_done_o
);

  localparam int unsigned EntryW  = IDX_W + 2;
  localparam logic [IDX_W-1:0] LastIdx = {IDX_W{1'b1}};

  bht_state_e       state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             resp_q;

  logic [29:0]      if_word, cm_word;
  logic [IDX_W-1:0] if_idx, cm_idx;
  logic             active, in_init, in_run;
  logic             lookup_gnt, write_gnt, cm_push;
  logic             fifo_full, fifo_empty;
  logic [EntryW-1:0] fifo_wdata, fifo_rdata;
  logic [IDX_W-1:0] head_idx;
  logic [1:0]       head_ctr;
  logic             unused_pc;

  assign if_word   = pc_word(if_pc_i);
  assign cm_word   = pc_word(cm_pc_i);
  assign if_idx    = if_word[IDX_W-1:0];
  assign cm_idx    = cm_word[IDX_W-1:0];
  assign unused_pc = ^{if_word[29:IDX_W], cm_word[29:IDX_W]};

  // Reset is folded in so the table port goes quiet the instant reset asserts
  assign active  = rdy_i & rst_ni;
  assign in_init = active & (state_q == StInit);
  assign in_run  = active & (state_q == StRun);

  // Fetch wins unless the queue is full, which forces a drain cycle
  assign lookup_gnt = in_run & if_req_i & ~fifo_full;
  assign write_gnt  = in_run & ~fifo_empty & (~if_req_i | fifo_full);

  // Readiness depends on occupancy only, never on a same-cycle dequeue
  assign cm_ready_o = in_run & ~fifo_full;
  assign cm_push    = cm_valid_i & cm_ready_o;
  assign if_stall_o = ~in_run | fifo_full;

  assign fifo_wdata = {cm_idx, ctr_next(cm_ctr_i, cm_taken_i)};
  assign {head_idx, head_ctr} = fifo_rdata;

  bht_update_fifo #(
    .DataW (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cm_push),
    .wdata_i (fifo_wdata),
    .pop_i   (write_gnt),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Table port mux: sweep write, fetch read, or queued counter write
  always_comb begin
    tbl_en_o    = 1'b0;
    tbl_we_o    = 1'b0;
    tbl_addr_o  = '0;
    tbl_wdata_o = '0;
    if (in_init) begin
      tbl_en_o    = 1'b1;
      tbl_we_o    = 1'b1;
      tbl_addr_o  = sweep_q;
      tbl_wdata_o = CTR_WNT;
    end else if (lookup_gnt) begin
      tbl_en_o   = 1'b1;
      tbl_addr_o = if_idx;
    end else if (write_gnt) begin
      tbl_en_o    = 1'b1;
      tbl_we_o    = 1'b1;
      tbl_addr_o  = head_idx;
      tbl_wdata_o = head_ctr;
    end
  end

  // Sweep sequencing: one entry per enabled cycle, RUN after the last entry
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (in_init) begin
      sweep_d = sweep_q + IDX_W'(1);
      if (sweep_q == LastIdx) begin
        state_d = StRun;
      end
    end
  end

  // FSM, sweep index and lookup-response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StInit;
      sweep_q <= '0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      // Response is only presented in the cycle right after the grant
      resp_q  <= lookup_gnt;
    end
  end

  assign if_resp_valid_o = resp_q & active;
  assign if_ctr_o        = if_resp_valid_o ? tbl_rdata_i : 2'b00;
  assign if_predict_o    = if_ctr_o[1];
  assign init_done_o     = (state_q == StRun);

endmodule

// File: tb/tb_bht_ctrl.sv
// Directed self-checking bench for bht_ctrl with a behavioural table RAM.
module tb_bht_ctrl;

  localparam int unsigned IdxW = 7;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rdy;
  logic            if_req;
  logic [31:0]     if_pc;
  logic            if_stall, if_resp_valid, if_predict;
  logic [1:0]      if_ctr;
  logic            cm_valid;
  logic [31:0]     cm_pc;
  logic            cm_taken;
  logic [1:0]      cm_ctr;
  logic            cm_ready;
  logic            tbl_en, tbl_we;
  logic [IdxW-1:0] tbl_addr;
  logic [1:0]      tbl_wdata;
  logic [1:0]      tbl_rdata = 2'b00;
  logic            init_done;

  logic [1:0]      mem [2**IdxW];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Single-port synchronous table RAM
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata <= mem[tbl_addr];
    end
  end

  bht_ctrl #(
    .IDX_W      (IdxW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .rdy_i           (rdy),
    .if_req_i        (if_req),
    .if_pc_i         (if_pc),
    .if_stall_o      (if_stall),
    .if_resp_valid_o (if_resp_valid),
    .if_predict_o    (if_predict),
    .if_ctr_o        (if_ctr),
    .cm_valid_i      (cm_valid),
    .cm_pc_i         (cm_pc),
    .cm_taken_i      (cm_taken),
    .cm_ctr_i        (cm_ctr),
    .cm_ready_o      (cm_ready),
    .tbl_en_o        (tbl_en),
    .tbl_we_o        (tbl_we),
    .tbl_addr_o      (tbl_addr),
    .tbl_wdata_o     (tbl_wdata),
    .tbl_rdata_i     (tbl_rdata),
    .init_done_o     (init_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_resp"},  {31'd0, if_resp_valid}, 32'd0);
    check({tag, "_pred"},  {31'd0, if_predict}, 32'd0);
    check({tag, "_ctr"},   {30'd0, if_ctr}, 32'd0);
    check({tag, "_stall"}, {31'd0, if_stall}, 32'd1);
    check({tag, "_ready"}, {31'd0, cm_ready}, 32'd0);
    check({tag, "_done"},  {31'd0, init_done}, 32'd0);
    check({tag, "_tbl"},   {28'd0, tbl_en, tbl_we, tbl_wdata}, 32'd0);
    check({tag, "_addr"},  {25'd0, tbl_addr}, 32'd0);
  endtask

  // {en, we, wdata} and address of the current table access
  task automatic chk_tbl(input string tag, input logic en, input logic we,
                         input logic [6:0] addr, input logic [1:0] wd);
    check({tag, "_ctl"}, {28'd0, tbl_en, tbl_we, tbl_wdata}, {28'd0, en, we, wd});
    if (en) check({tag, "_addr"}, {25'd0, tbl_addr}, {25'd0, addr});
  endtask

  // Drive one cycle's inputs at the falling edge, then settle
  task automatic step(input logic r, input logic req, input logic [31:0] pc,
                      input logic cv, input logic [31:0] cpc, input logic ct,
                      input logic [1:0] cc);
    @(negedge clk);
    rdy = r; if_req = req; if_pc = pc;
    cm_valid = cv; cm_pc = cpc; cm_taken = ct; cm_ctr = cc;
    #1;
  endtask

  // Release reset on the first cycle and check n consecutive sweep writes
  task automatic do_sweep(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      #1;
      check("sweep_addr", {25'd0, tbl_addr}, i);
      check("sweep_ctl", {25'd0, tbl_en, tbl_we, tbl_wdata, init_done, if_stall, cm_ready},
            32'b1101010);
    end
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; if_req = 1'b0; if_pc = '0;
    cm_valid = 1'b0; cm_pc = '0; cm_taken = 1'b0; cm_ctr = '0;

    @(negedge clk); #1;
    chk_reset("por");

    // Partial sweep, then reset while sweeping index 60
    do_sweep(60);
    @(negedge clk); #1;
    check("sweep60_addr", {25'd0, tbl_addr}, 32'd60);
    #2 rst_n = 1'b0;
    #1 chk_reset("midreset");
    @(negedge clk); #1;
    chk_reset("inreset");

    // Full restarted sweep
    do_sweep(128);
    step(1, 0, 0, 0, 0, 0, 2'b00);
    check("done", {31'd0, init_done}, 32'd1);
    check("run_stall", {31'd0, if_stall}, 32'd0);
    check("run_ready", {31'd0, cm_ready}, 32'd1);
    chk_tbl("run_idle", 0, 0, 0, 0);

    // Lookup of 0x104 -> index 0x41, swept value 01
    step(1, 1, 32'h104, 0, 0, 0, 2'b00);
    chk_tbl("lk1", 1, 0, 7'h41, 0);
    check("lk1_stall", {31'd0, if_stall}, 32'd0);
    step(1, 0, 0, 0, 0, 0, 2'b00);
    check("lk1_valid", {31'd0, if_resp_valid}, 32'd1);
    check("lk1_pred", {31'd0, if_predict}, 32'd0);
    check("lk1_ctr", {30'd0, if_ctr}, 32'd1);

    // Three commits covering both saturations and a mid-range step
    step(1, 0, 0, 1, 32'h104, 1, 2'b11);
    check("u1_ready", {31'd0, cm_ready}, 32'd1);
    check("u1_valid0", {31'd0, if_resp_valid}, 32'd0);
    step(1, 0, 0, 1, 32'h108, 0, 2'b00);
    chk_tbl("u1_wr", 1, 1, 7'h41, 2'b11);
    step(1, 0, 0, 1, 32'h10C, 1, 2'b01);
    chk_tbl("u2_wr", 1, 1, 7'h42, 2'b00);
    step(1, 0, 0, 0, 0, 0, 2'b00);
    chk_tbl("u3_wr", 1, 1, 7'h43, 2'b10);
    step(1, 1, 32'h104, 0, 0, 0, 2'b00);
    chk_tbl("lk2", 1, 0, 7'h41, 0);
    step(1, 0, 0, 0, 0, 0, 2'b00);
    chk_tbl("lk2_idle", 0, 0, 0, 0);
    check("lk2_valid", {31'd0, if_resp_valid}, 32'd1);
    check("lk2_pred", {31'd0, if_predict}, 32'd1);
    check("lk2_ctr", {30'd0, if_ctr}, 32'd3);

    // Continuous fetch while four updates queue up
    step(1, 1, 32'h180, 1, 32'h010, 0, 2'b11);
    chk_tbl("f1", 1, 0, 7'h60, 0);
    step(1, 1, 32'h180, 1, 32'h014, 1, 2'b00);
    chk_tbl("f2", 1, 0, 7'h60, 0);
    step(1, 1, 32'h180, 1, 32'h018, 1, 2'b10);
    chk_tbl("f3", 1, 0, 7'h60, 0);
    step(1, 1, 32'h180, 1, 32'h01C, 0, 2'b01);
    check("f4_ready", {31'd0, cm_ready}, 32'd1);
    chk_tbl("f4", 1, 0, 7'h60, 0);
    // Queue full: forced drain, refused fifth update
    step(1, 1, 32'h180, 1, 32'h020, 1, 2'b00);
    check("full_ready", {31'd0, cm_ready}, 32'd0);
    check("full_stall", {31'd0, if_stall}, 32'd1);
    check("full_valid", {31'd0, if_resp_valid}, 32'd1);
    chk_tbl("full_wr", 1, 1, 7'h04, 2'b10);
    step(1, 1, 32'h180, 0, 0, 0, 2'b00);
    check("resume_stall", {31'd0, if_stall}, 32'd0);
    check("resume_ready", {31'd0, cm_ready}, 32'd1);
    check("resume_valid", {31'd0, if_resp_valid}, 32'd0);
    chk_tbl("resume_rd", 1, 0, 7'h60, 0);
    step(1, 0, 0, 0, 0, 0, 2'b00);
    chk_tbl("drain2", 1, 1, 7'h05, 2'b01);
    step(1, 0, 0, 0, 0, 0, 2'b00);
    chk_tbl("drain3", 1, 1, 7'h06, 2'b11);
    step(1, 0, 0, 0, 0, 0, 2'b00);
    chk_tbl("drain4", 1, 1, 7'h07, 2'b00);
    step(1, 0, 0, 0, 0, 0, 2'b00);
    chk_tbl("drained", 0, 0, 0, 0);

    // rdy low for three cycles with one update queued
    step(1, 1, 32'h180, 1, 32'h024, 1, 2'b10);
    chk_tbl("rq_rd", 1, 0, 7'h60, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h180, 1, 32'h028, 0, 2'b11);
      chk_tbl("frz", 0, 0, 0, 0);
      check("frz_flags", {29'd0, if_stall, cm_ready, if_resp_valid}, 32'b100);
    end
    step(1, 0, 0, 0, 0, 0, 2'b00);
    chk_tbl("unfrz_wr", 1, 1, 7'h09, 2'b11);
    step(1, 0, 0, 0, 0, 0, 2'b00);
    chk_tbl("unfrz_empty", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
